// File: rtl/amm_burst_master.sv
// amm_burst_master: Avalon-MM master running multi-word write/read commands, with
// pipelined reads capped at MAX_PENDING outstanding and a running read checksum.
module amm_burst_master #(
    parameter int ADDRESSWIDTH = 28,
    parameter int DATAWIDTH    = 32,
    parameter int MAX_BURST    = 16,
    parameter int MAX_PENDING  = 4,
    localparam int LENW        = $clog2(MAX_BURST) + 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDRESSWIDTH-1:0]   cmd_addr,
    input  logic [LENW-1:0]           cmd_len,
    input  logic [DATAWIDTH-1:0]      cmd_seed,
    output logic [ADDRESSWIDTH-1:0]   avm_address,
    output logic                      avm_read,
    output logic                      avm_write,
    output logic [DATAWIDTH-1:0]      avm_writedata,
    output logic [DATAWIDTH/8-1:0]    avm_byteenable,
    input  logic                      avm_waitrequest,
    input  logic [DATAWIDTH-1:0]      avm_readdata,
    input  logic                      avm_readdatavalid,
    output logic                      busy,
    output logic                      done,
    output logic [DATAWIDTH-1:0]      last_rdata,
    output logic [DATAWIDTH-1:0]      rd_sum
);
    localparam int BYTES = DATAWIDTH / 8;
    localparam int PW    = $clog2(MAX_PENDING + 1);

    typedef enum logic [2:0] {IDLE, WR, RD, DRAIN, DONE} state_t;

    state_t                    state_q;
    logic [LENW-1:0]           rem_q, rem_d, len_c;
    logic [PW-1:0]             out_q, out_d;
    logic [ADDRESSWIDTH-1:0]   addr_q;
    logic [DATAWIDTH-1:0]      wdata_q, last_q, sum_q;
    logic                      rd_q, wr_q, busy_q, done_q, ready_q;
    logic                      xfer, rd_fire, rdv_ok, accept;

    always_comb begin
        xfer    = (rd_q || wr_q) && !avm_waitrequest;
        rd_fire = rd_q && !avm_waitrequest;
        rdv_ok  = avm_readdatavalid && (state_q == RD || state_q == DRAIN);
        out_d   = out_q + PW'(rd_fire) - PW'(rdv_ok);
        rem_d   = rem_q - LENW'(xfer);
        len_c   = (cmd_len > LENW'(MAX_BURST)) ? LENW'(MAX_BURST) : cmd_len;
        accept  = cmd_valid && ready_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            out_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            last_q  <= '0;
            sum_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            out_q  <= out_d;
            rem_q  <= rem_d;
            if (rdv_ok) begin
                last_q <= avm_readdata;
                sum_q  <= sum_q + avm_readdata;
            end
            // Address/data only move on a completed transfer, so they hold under waitrequest
            if (xfer)
                addr_q <= addr_q + ADDRESSWIDTH'(BYTES);
            if (wr_q && !avm_waitrequest)
                wdata_q <= wdata_q + DATAWIDTH'(1);
            case (state_q)
                IDLE: if (accept) begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b1;
                    addr_q  <= cmd_addr;
                    wdata_q <= cmd_seed;
                    rem_q   <= len_c;
                    if (!cmd_write)
                        sum_q <= '0;
                    if (len_c == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (cmd_write) begin
                        state_q <= WR;
                        wr_q    <= 1'b1;
                    end else begin
                        state_q <= RD;
                        rd_q    <= 1'b1;
                    end
                end
                WR: if (rem_d == '0) begin
                    wr_q    <= 1'b0;
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                RD: begin
                    rd_q <= (rem_d != '0) && (out_d < PW'(MAX_PENDING));
                    if (rem_d == '0)
                        state_q <= DRAIN;
                end
                DRAIN: if (out_d == '0) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready      = ready_q;
    assign avm_address    = addr_q;
    assign avm_read       = rd_q;
    assign avm_write      = wr_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = '1;
    assign busy           = busy_q;
    assign done           = done_q;
    assign last_rdata     = last_q;
    assign rd_sum         = sum_q;
endmodule
